lamp_access_arbiter: RTL

//  Shares the single lamp driver among NREQ command sources (keypad, wall switch, scheduler, ...).

---
 rtl/light_ctrl_pkg.sv | 24 ++
 rtl/rr_picker.sv | 31 +++
 rtl/lamp_access_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/light_ctrl_pkg.sv
// Shared definitions for the lamp access arbiter and the per-source light FSMs:
// arbiter state encoding, lamp level constants and the auto-off source id.
package light_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_DRIVE,
    ST_SETTLE
  } arb_state_e;

  localparam logic LAMP_ON  = 1'b1;
  localparam logic LAMP_OFF = 1'b0;

  localparam int DEFAULT_NREQ = 3;

  // Source id reported for the arbiter's own auto-off command (one past the last requester).
  localparam int AUTO_SRC = DEFAULT_NREQ;

  function automatic int next_ptr(input int src, input int nreq);
    return (src + 1) % nreq;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: rotate requests so ptr_i sits at bit 0,
// isolate the lowest set bit, rotate back. Returns one-hot winner and its index.
module rr_picker #(
  parameter  int NREQ = 3,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [IW-1:0]   idx_o
);

  logic [2*NREQ-1:0] req_dbl;
  logic [2*NREQ-1:0] pick_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [NREQ-1:0]   pick_rot;

  always_comb begin
    // NOTE: every output gets a default before any conditional write, so no latch is inferred.
    idx_o    = '0;
    req_dbl  = {req_i, req_i} >> ptr_i;
    req_rot  = req_dbl[NREQ-1:0];
    pick_rot = req_rot & (~req_rot + NREQ'(1));
    pick_dbl = {pick_rot, pick_rot} << ptr_i;
    onehot_o = pick_dbl[2*NREQ-1:NREQ];
    for (int i = 0; i < NREQ; i++) begin
      if (onehot_o[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/lamp_access_arbiter.sv
// Round-robin arbiter giving NREQ command sources exclusive access to the lamp driver,
// with a settle gap after every driver handshake. Optional auto-off timer: LAMP_AUTO_OFF_EN.
module lamp_access_arbiter
  import light_ctrl_pkg::*;
#(
  parameter int NREQ       = DEFAULT_NREQ,
  parameter int SETTLE_CYC = 4
`ifdef LAMP_AUTO_OFF_EN
  , parameter int AUTO_OFF_CYC = 1000
`endif
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           cmd_on,
  output logic [NREQ-1:0]           gnt,
  output logic                      drv_valid,
  output logic                      drv_on,
  input  logic                      drv_ready,
  output logic                      lamp_on,
  output logic                      busy,
  output logic [$clog2(NREQ+1)-1:0] last_src
);

  localparam int IW = $clog2(NREQ);
  localparam int SW = $clog2(NREQ + 1);
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  arb_state_e      state_q;
  logic [IW-1:0]   ptr_q;
  logic [SW-1:0]   src_q;
  logic            cmd_q;
  logic [CW-1:0]   settle_q;
  logic [NREQ-1:0] gnt_q;
  logic            drv_valid_q;
  logic            drv_on_q;
  logic            lamp_on_q;
  logic            busy_q;
  logic [SW-1:0]   last_src_q;

  logic [NREQ-1:0] pick_onehot;
  logic [IW-1:0]   pick_idx;
  logic            handshake;

  assign handshake = (state_q == ST_DRIVE) && drv_ready;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx)
  );

`ifdef LAMP_AUTO_OFF_EN
  localparam int TW = $clog2(AUTO_OFF_CYC);

  logic [TW-1:0] timer_q, timer_d;
  logic          auto_off_due;

  // Any ON grant (applied or redundant) restarts the on-time window; lamp going off clears it.
  always_comb begin
    timer_d = timer_q;
    if ((handshake && drv_on_q == LAMP_ON) ||
        (state_q == ST_GRANT && cmd_q == LAMP_ON && lamp_on_q == LAMP_ON))
      timer_d = TW'(AUTO_OFF_CYC - 1);
    else if (handshake)
      timer_d = '0;
    else if (lamp_on_q == LAMP_ON && timer_q != '0)
      timer_d = timer_q - TW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) timer_q <= '0;
    else          timer_q <= timer_d;
  end

  assign auto_off_due = (lamp_on_q == LAMP_ON) && (timer_q == '0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      src_q       <= '0;
      cmd_q       <= LAMP_OFF;
      settle_q    <= '0;
      gnt_q       <= '0;
      drv_valid_q <= 1'b0;
      drv_on_q    <= LAMP_OFF;
      lamp_on_q   <= LAMP_OFF;
      busy_q      <= 1'b0;
      last_src_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees pre-edge state.
      gnt_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            src_q   <= SW'(pick_idx);
            cmd_q   <= |(cmd_on & pick_onehot);
            gnt_q   <= pick_onehot;
            busy_q  <= 1'b1;
            state_q <= ST_GRANT;
          end
`ifdef LAMP_AUTO_OFF_EN
          else if (auto_off_due) begin
            src_q       <= SW'(NREQ);
            cmd_q       <= LAMP_OFF;
            drv_valid_q <= 1'b1;
            drv_on_q    <= LAMP_OFF;
            busy_q      <= 1'b1;
            state_q     <= ST_DRIVE;
          end
`endif
        end
        ST_GRANT: begin
          ptr_q <= IW'(next_ptr(int'(src_q), NREQ));
          if (cmd_q == lamp_on_q) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            drv_valid_q <= 1'b1;
            drv_on_q    <= cmd_q;
            state_q     <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (handshake) begin
            drv_valid_q <= 1'b0;
            lamp_on_q   <= drv_on_q;
            last_src_q  <= src_q;
            settle_q    <= CW'(SETTLE_CYC - 1);
            state_q     <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            settle_q <= settle_q - CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign drv_valid = drv_valid_q;
  assign drv_on    = drv_on_q;
  assign lamp_on   = lamp_on_q;
  assign busy      = busy_q;
  assign last_src  = last_src_q;

endmodule
